// File: rtl/debruijn_seq_ctrl.sv
// rtl/debruijn_seq_ctrl.sv - de Bruijn bit-sequence generator with valid/ready output and IDLE/RUN/DONE control
module debruijn_seq_ctrl #(
  parameter int          N    = 4,
  parameter logic [N-1:0] TAPS = 4'b1100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         cont,
  input  logic [N-1:0] seed,
  input  logic         bit_ready,
  output logic         bit_out,
  output logic         bit_valid,
  output logic [N-1:0] sr_state,
  output logic [N-1:0] bit_cnt,
  output logic         busy,
  output logic         wrap,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] s;
  logic [N-1:0] cnt;
  logic         cont_q;
  logic         wrap_q;
  logic         fb;
  logic         xfer;
  logic         last;
  logic         load;

  // The zero-detect term splices the all-zero state into the maximal LFSR
  // cycle, stretching the period from 2^N-1 to 2^N.
  always_comb begin
    xfer = (state == RUN) && bit_ready;
    last = (cnt == {N{1'b1}});
    fb   = (^(s & TAPS)) ^ (s[N-2:0] == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    bit_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
        if (stop) begin
          state_next = IDLE;
        end else if (xfer && last && !cont_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register and counter move only on a transfer; IDLE keeps last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s      <= '0;
      cnt    <= '0;
      cont_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= xfer && last;
      if (load) begin
        s      <= seed;
        cnt    <= '0;
        cont_q <= cont;
      end else if (xfer) begin
        s   <= {s[N-2:0], fb};
        cnt <= cnt + {{(N-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bit_out  = s[N-1];
  assign sr_state = s;
  assign bit_cnt  = cnt;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_debruijn_seq_ctrl.sv
// tb/tb_debruijn_seq_ctrl.sv - self-checking bench for debruijn_seq_ctrl
module tb_debruijn_seq_ctrl;

  localparam int N = 4;
  localparam int TAPS_I = 12;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         cont;
  logic [N-1:0] seed;
  logic         bit_ready;
  logic         bit_out;
  logic         bit_valid;
  logic [N-1:0] sr_state;
  logic [N-1:0] bit_cnt;
  logic         busy;
  logic         wrap;
  logic         done;

  int n_chk;
  int n_fail;

  debruijn_seq_ctrl #(.N(N), .TAPS(4'b1100)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .seed(seed), .bit_ready(bit_ready), .bit_out(bit_out),
    .bit_valid(bit_valid), .sr_state(sr_state), .bit_cnt(bit_cnt),
    .busy(busy), .wrap(wrap), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: mode 0=idle, 1=running, 2=finished; integers only.
  int m_mode;
  int m_s;
  int m_cnt;
  int m_cont;
  int m_wrap;

  function automatic int next_bit_state(int cur);
    int ones;
    int fb;
    ones = 0;
    for (int k = 0; k < N; k++)
      if (((cur >> k) & 1) == 1 && ((TAPS_I >> k) & 1) == 1) ones++;
    fb = (ones % 2) ^ (((cur % (1 << (N - 1))) == 0) ? 1 : 0);
    return (cur * 2 + fb) % (1 << N);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_s = 0; m_cnt = 0; m_cont = 0; m_wrap = 0;
  endfunction

  function automatic void model_edge();
    int  nmode;
    bit  moved;
    bit  was_last;
    nmode    = m_mode;
    moved    = (m_mode == 1) && bit_ready;
    was_last = (m_cnt == (1 << N) - 1);
    m_wrap   = (moved && was_last) ? 1 : 0;
    if (m_mode == 0) begin
      if (start && !stop) begin
        nmode = 1; m_s = int'(seed); m_cnt = 0; m_cont = int'(cont);
      end
    end else if (m_mode == 1) begin
      if (moved) begin
        m_s   = next_bit_state(m_s);
        m_cnt = (m_cnt + 1) % (1 << N);
      end
      if (stop) nmode = 0;
      else if (moved && was_last && m_cont == 0) nmode = 2;
    end else begin
      nmode = 0;
    end
    m_mode = nmode;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_bit_out",   32'(bit_out),   32'((m_s >> (N - 1)) & 1));
    chk("m_bit_valid", 32'(bit_valid), 32'(m_mode == 1));
    chk("m_sr_state",  32'(sr_state),  32'(m_s));
    chk("m_bit_cnt",   32'(bit_cnt),   32'(m_cnt));
    chk("m_busy",      32'(busy),      32'(m_mode != 0));
    chk("m_wrap",      32'(wrap),      32'(m_wrap));
    chk("m_done",      32'(done),      32'(m_mode == 2));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset(); else model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [3:0] sr;
    logic       bo;
    logic       valid;
    logic       wr;
    logic       dn;
  } vec_t;

  vec_t       tbl[17];
  logic [3:0] srs[16];
  logic [15:0] bstr;
  int         k;
  int         cyc;
  logic       prev_bo;
  logic       prev_rdy;
  bit         hit;

  initial begin
    srs  = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    bstr = 16'b0001001101011110;
    for (int i = 0; i < 16; i++) tbl[i] = '{srs[i], bstr[15 - i], 1'b1, 1'b0, 1'b0};
    tbl[16] = '{4'h1, 1'b0, 1'b0, 1'b1, 1'b1};

    n_chk = 0; n_fail = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; seed = '0; bit_ready = 1'b0;
    model_reset();
    #12;
    compare_model();
    chk("reset_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();

    // One period, cont=0, ready always high
    seed = 4'h1; cont = 1'b0; bit_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("tbl_sr",    32'(sr_state),  32'(tbl[i].sr));
      chk("tbl_bo",    32'(bit_out),   32'(tbl[i].bo));
      chk("tbl_valid", 32'(bit_valid), 32'(tbl[i].valid));
      chk("tbl_wrap",  32'(wrap),      32'(tbl[i].wr));
      chk("tbl_done",  32'(done),      32'(tbl[i].dn));
      step();
    end
    chk("after_done_busy", 32'(busy), 32'd0);

    // Same period with ready toggling: stream identical, output holds on stalls
    seed = 4'h1; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 0; prev_rdy = 1'b1; prev_bo = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (k < 16) chk("stall_stream", 32'(bit_out), 32'(bstr[15 - k]));
      if (!prev_rdy && k < 16) chk("stall_hold", 32'(bit_out), 32'(prev_bo));
      bit_ready = (i % 2 == 0);
      prev_rdy = bit_ready;
      prev_bo  = bit_out;
      step();
      if (prev_rdy) k++;
    end
    bit_ready = 1'b1;
    step();

    // Free-run from the all-zero seed
    seed = 4'h0; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 39; i++) begin
      step();
      cyc++;
      chk("cont_wrap", 32'(wrap), 32'(cyc == 17 || cyc == 33));
      if (cyc == 17 || cyc == 33) chk("cont_sr_seed", 32'(sr_state), 32'd0);
      chk("cont_busy", 32'(busy), 32'd1);
      chk("cont_done", 32'(done), 32'd0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("cont_stop_valid", 32'(bit_valid), 32'd0);

    // Stop at bit_cnt=5, then restart with seed 1000
    seed = 4'h1; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bit_cnt == 4'd5) hit = 1'b1;
      else step();
    end
    chk("stop_reached_cnt5", 32'(hit), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_cnt", 32'(bit_cnt), 32'd6);
    chk("stop_valid", 32'(bit_valid), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    step();
    chk("stop_no_done_late", 32'(done), 32'd0);
    seed = 4'h8; start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_bo", 32'(bit_out), 32'd1);
    chk("restart_valid", 32'(bit_valid), 32'd1);
    seed = 4'h3; cont = 1'b1; start = 1'b1;
    step();
    step();
    start = 1'b0;

    // Asynchronous reset between edges mid-run
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_model();
    chk("arst_valid", 32'(bit_valid), 32'd0);
    chk("arst_sr", 32'(sr_state), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_done", 32'(done), 32'd0);
    #2;
    rst = 1'b1;
    seed = 4'h5; cont = 1'b0; start = 1'b1; stop = 1'b1;
    step();
    chk("start_stop_idle", 32'(busy), 32'd0);
    stop = 1'b0;
    step();
    start = 1'b0;
    chk("start_run", 32'(bit_valid), 32'd1);
    chk("start_run_sr", 32'(sr_state), 32'd5);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      cont      = $urandom_range(0, 1);
      seed      = N'($urandom_range(0, 15));
      bit_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debruijn_seq_ctrl.md
DEBRUIJN_SEQ_CTRL -- requirements
Module: debruijn_seq_ctrl

Interface
REQ-001 Parameter N, default 4: sequence order, equal to the shift-register width; legal range 2..16.
REQ-002 Parameter TAPS, default 4'b1100 (N bits): primitive feedback tap mask; bit i set means s[i] feeds the XOR.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to load seed and begin generating; sampled only in IDLE.
REQ-006 stop  input  1  abort; sampled in RUN; stop wins over start in the same cycle.
REQ-007 cont  input  1  0 = generate one period and finish; 1 = free-run; sampled at start.
REQ-008 seed  input  N  initial shift-register state; any value, including 0, is legal.
REQ-009 bit_ready  input  1  consumer accepts bit_out this cycle.
REQ-010 bit_out  output  1  current sequence bit, s[N-1].
REQ-011 bit_valid  output  1  bit_out is valid; high exactly while in RUN.
REQ-012 sr_state  output  N  current shift-register contents s[N-1:0].
REQ-013 bit_cnt  output  N  bits accepted in the current period, 0..2^N-1.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 wrap  output  1  one-cycle pulse when a full period of 2^N bits has been accepted.
REQ-016 done  output  1  one-cycle pulse in the DONE state.

Function
REQ-017 FSM states SHALL be: IDLE, RUN, DONE.
- IDLE -> RUN on start=1: s <= seed, bit_cnt <= 0, cont latched.
- RUN -> IDLE on stop=1.
- RUN -> DONE on the last accepted bit of a period when cont=0.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 A transfer SHALL occur when bit_valid=1 and bit_ready=1; s and bit_cnt SHALL change only on a transfer.
REQ-019 On a transfer, s <= {s[N-2:0], fb}, where fb = XOR-reduce(s & TAPS) XOR (s[N-2:0] == 0); this gives a period of 2^N that includes the all-zero state.
REQ-020 bit_valid SHALL assert the cycle after start is accepted, with bit_out = seed[N-1]; there is no bubble between consecutive transfers.
REQ-021 If bit_valid=1 and bit_ready=0, bit_out, sr_state and bit_cnt SHALL hold stable.
REQ-022 On each transfer, bit_cnt increments; on the transfer at bit_cnt = 2^N-1 it wraps to 0 and wrap pulses in the following cycle.
REQ-023 In cont=1, RUN continues across the wrap indefinitely; sr_state returns to seed at each wrap.
REQ-024 stop in RUN SHALL drop bit_valid the next cycle; a transfer in the same cycle as stop still completes; done does not pulse; wrap may still pulse if that transfer was the period's last.
REQ-025 start while busy=1 SHALL be ignored; seed and cont SHALL be ignored outside IDLE.
REQ-026 In IDLE, sr_state and bit_cnt SHALL hold their last values.

Reset
REQ-027 While rst=0, asynchronously set: FSM = IDLE, s = 0, bit_cnt = 0.
REQ-028 While rst=0: bit_valid = busy = wrap = done = 0.
REQ-029 rst asserted mid-RUN SHALL abort immediately with no done pulse.
REQ-030 After rst deasserts, the first start is accepted on the next rising edge.

Verification
REQ-031 N=4, TAPS=1100, seed=0001, cont=0, bit_ready=1 ->
- sr_state: 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,0
- bit_out: 0001001101011110
- wrap at cycle 17, done at cycle 17, then IDLE
REQ-032 Same as REQ-031 with bit_ready toggling 1/0 each cycle -> identical bit stream over 32 cycles; bit_out stable on every ready=0 cycle.
REQ-033 cont=1, seed=0000, ready=1 for 40 cycles ->
- wrap pulses at cycles 17 and 33
- sr_state = 0000 after each wrap
- busy stays high throughout; done never pulses
REQ-034 stop asserted at bit_cnt=5 with ready=1 ->
- bit_cnt = 6 on the next cycle, bit_valid = 0, IDLE
- no done pulse
- a new start with seed=1000 then begins at bit_out=1
REQ-035 rst pulsed low for 1 cycle mid-RUN (asynchronously, between edges) ->
- outputs clear immediately
- start and stop asserted together in IDLE -> stays IDLE
- start alone -> RUN
